uart_echo_ctrl: RTL
===================

Name: uart_echo_ctrl

Overview:
Sequencer between the UART receiver and UART transmitter of the echo design. Buffers received bytes in a small FIFO and hands them one at a time to the transmitter using a start/busy handshake. Publishes the last echoed byte and a running echo count to the 7-seg driver, and stretches a per-echo activity pulse onto the LED.

Parameters:
FIFO_DEPTH, 8, entries in the receive buffer; power of two, >= 2
LED_HOLD, 5_000_000, clk cycles the LED stays lit after each completed echo; >= 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_err  in  1  framing error, qualifies rx_valid in the same cycle
tx_data  out  8  byte to UART transmitter, held stable from START until return to IDLE
tx_start  out  1  one-cycle pulse requesting transmission
tx_busy  in  1  transmitter busy, high for the whole frame
disp_byte  out  8  last fully echoed byte, to 7-seg driver
disp_count  out  8  echoed-byte count mod 256, to 7-seg driver
led  out  1  activity indicator
overflow  out  1  sticky, a byte was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync deassert handled upstream): FSM=IDLE, FIFO empty, and every output = 0, including tx_data, disp_byte, disp_count, led and overflow.
- Push: rx_valid=1 and rx_err=0 at an edge writes rx_data. rx_valid with rx_err=1 is discarded, with no other effect.
- Full: a push while full with no pop in the same cycle drops the byte and sets overflow. overflow clears only on reset.
- Full with push and pop in the same cycle: the push is accepted; occupancy is unchanged.
- Empty with push and pop in the same cycle: cannot occur. A pop requires not-empty at the edge, so there is no fall-through.
- FSM states, one transition per edge:
  - IDLE: if the FIFO is not empty and tx_busy=0, pop the head into tx_data -> START.
  - START: tx_start=1 for exactly this cycle -> WAIT_ACK.
  - WAIT_ACK: on tx_busy=1 -> WAIT_DONE.
  - WAIT_DONE: on tx_busy=0, set disp_byte<=tx_data, disp_count<=disp_count+1 (wraps 255->0) and reload the LED counter -> IDLE.
- Latency: rx_valid in cycle N with IDLE and an empty FIFO gives tx_start=1 in cycle N+2.
- Back-to-back echoes: minimum gap of 1 IDLE cycle between transmissions.
- LED: counter loads LED_HOLD on echo completion; decrements to 0; led = (counter != 0). A completion while lit reloads the counter (retrigger).
- Width: the LED counter is $clog2(LED_HOLD+1) bits. FIFO pointers are $clog2(FIFO_DEPTH)+1 bits, with the extra bit for full/empty.
- tx_busy high in IDLE (transmitter occupied externally) blocks the pop. The FIFO keeps filling.
- Reset mid-operation, in any state: immediate return to reset values. Buffered bytes are lost and no tx_start is issued.

Decomposition:
- Package uart_echo_pkg:
  - byte_t (logic [7:0])
  - echo_state_t enum {IDLE, START, WAIT_ACK, WAIT_DONE}
  - default parameter constants
- Sub-module byte_fifo: synchronous FIFO parameterised by depth and width. Outputs full, empty and head data; inputs push and pop. Same clk/rst.
- The FSM, display registers and LED stretcher stay in uart_echo_ctrl.

Test Plan:
1. Single echo: rx 0x41 with the bench transmitter model busy for 10 cycles after tx_start.
   -> tx_start in cycle N+2 with tx_data=0x41.
   -> After busy falls: disp_byte=0x41, disp_count=1, led=1 for LED_HOLD cycles (set to 16 in sim), then 0.
2. Burst overflow: FIFO_DEPTH=8; rx 0x00..0x09 back-to-back while the transmitter frame is long.
   -> Echoes 0x00..0x08 in order; 0x09 dropped.
   -> overflow=1, disp_count=9.
3. Error discard: rx_valid with rx_err=1, data 0x55.
   -> No tx_start; FIFO stays empty; disp_count and overflow unchanged.
4. Full push+pop: fill FIFO to 8 with IDLE blocked by tx_busy=1. Release busy and push 0xAA in the same cycle as the pop.
   -> overflow stays 0; 0xAA is echoed last.
5. Reset mid-frame: assert rst during WAIT_DONE with 3 bytes queued.
   -> All outputs 0 immediately; no further tx_start.
   -> After release, rx 0x7E echoes normally with disp_count=1.
6. Wrap: echo 256 bytes.
   -> disp_count returns to 0x00; disp_byte equals the 256th byte.

Source files
------------

// File: rtl/uart_echo_pkg.sv
// Shared types and default constants for the UART echo sequencer.
package uart_echo_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } echo_state_t;

    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_LED_HOLD   = 5_000_000;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with extended-pointer full/empty detection and a registered memory.
module byte_fifo
    import uart_echo_pkg::*;
#(
    parameter int DEPTH  = DEF_FIFO_DEPTH,
    parameter int DATA_W = $bits(byte_t)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full FIFO is still accepted when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo sequencer: buffers received bytes, hands them to the transmitter one at a time,
// and drives the 7-seg display registers and the activity LED.
module uart_echo_ctrl
    import uart_echo_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LED_HOLD   = DEF_LED_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [7:0] disp_byte,
    output logic [7:0] disp_count,
    output logic       led,
    output logic       overflow
);

    localparam int LED_W = $clog2(LED_HOLD + 1);

    echo_state_t state;
    byte_t       head;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        echo_done;
    logic [LED_W-1:0] led_cnt;

    assign push      = rx_valid && !rx_err;
    assign pop       = (state == IDLE) && !empty && !tx_busy;
    assign echo_done = (state == WAIT_DONE) && !tx_busy;
    assign tx_start  = (state == START);
    assign led       = (led_cnt != '0);

    byte_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W ($bits(byte_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rx_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_data    <= '0;
            disp_byte  <= '0;
            disp_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= head;
                        state   <= START;
                    end
                end
                START:    state <= WAIT_ACK;
                WAIT_ACK: if (tx_busy) state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        disp_byte  <= tx_data;
                        disp_count <= disp_count + 8'd1;
                        state      <= IDLE;
                    end
                end
                default:  state <= IDLE;
            endcase
        end
    end

    // Each completed echo retriggers the LED hold time, even while already lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_cnt <= '0;
        end else if (echo_done) begin
            led_cnt <= LED_W'(LED_HOLD);
        end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - LED_W'(1);
        end
    end

endmodule
